// File: rtl/uart_pkg.sv
// Shared UART definitions: clocking defaults, framing constants and the TX FSM state type.
package uart_pkg;

  localparam int CLK_HZ           = 100_000_000;
  localparam int BAUD             = 9600;
  localparam int DEF_CLKS_PER_BIT = CLK_HZ / BAUD;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO with first-word fall-through: the head is always visible on dout.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int LVL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int AW = LVL_W - 1;

  logic [7:0]       mem [DEPTH];
  logic [LVL_W-1:0] wr_ptr;
  logic [LVL_W-1:0] rd_ptr;

  // Pointers carry one extra MSB so that full and empty can be told apart.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + LVL_W'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + LVL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: FIFO-fed serialiser, LSB first, registered line output.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4,
  parameter int LVL_W        = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             uart_rxd_out,
  output logic             busy,
  output logic [LVL_W-1:0] fifo_level
);

  localparam int            BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  tx_state_t     state;
  tx_state_t     state_next;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          line_q;
  logic          line_next;
  logic          pop;
  logic          baud_done;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid & tx_ready),
    .pop   (pop),
    .din   (tx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign baud_done = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (!fifo_empty) state_next = START;
      START: if (baud_done) state_next = DATA;
      DATA:  if (baud_done && bit_idx == LAST_BIT) state_next = STOP;
      STOP:  if (baud_done) state_next = fifo_empty ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  // Line value is chosen for the state being entered so the register lines up with it.
  always_comb begin
    pop       = 1'b0;
    line_next = 1'b1;
    if (!fifo_empty && (state == IDLE || (state == STOP && baud_done))) begin
      pop = 1'b1;
    end
    case (state_next)
      START:   line_next = 1'b0;
      DATA:    line_next = (state == DATA && baud_done) ? shift_reg[1] : shift_reg[0];
      default: line_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      line_q    <= 1'b1;
    end else begin
      line_q <= line_next;
      if (state == IDLE || baud_done) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + BW'(1);
      end
      if (state == START) begin
        bit_idx <= '0;
      end else if (state == DATA && baud_done) begin
        bit_idx <= bit_idx + 3'd1;
      end
      if (pop) begin
        shift_reg <= fifo_dout;
      end else if (state == DATA && baud_done) begin
        shift_reg <= {1'b0, shift_reg[7:1]};
      end
    end
  end

  assign uart_rxd_out = line_q;
  assign tx_ready     = !fifo_full;
  assign busy         = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-timing reference model, independent 8N1 decoder, vector table.
module tb_uart_tx;

  localparam int C     = 4;
  localparam int DEPTH = 4;
  localparam int LVL_W = 3;

  logic             clk;
  logic             rst;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             line;
  logic             busy;
  logic [LVL_W-1:0] fifo_level;

  int checks = 0;
  int errors = 0;

  // Reference model: pending bytes plus the position inside the current frame.
  logic [7:0] mq[$];
  bit         m_active;
  logic [7:0] m_frame;
  int         m_cyc;
  bit         m_accept;
  logic [7:0] exp_q[$];

  // Independent decoder state.
  bit         dec_active;
  int         dec_cnt;
  logic [9:0] dec_bits;
  bit         prev_line;
  logic [7:0] dec_q[$];

  typedef struct {
    bit         rst;
    bit         valid;
    logic [7:0] data;
    bit         line;
    bit         ready;
    bit         busy;
    int         level;
  } vec_t;

  vec_t vecs[6];
  bit   a5_bits[10];

  uart_tx #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (DEPTH),
    .LVL_W        (LVL_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .uart_rxd_out (line),
    .busy         (busy),
    .fifo_level   (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit modelLine();
    int k;
    if (!m_active) return 1'b1;
    k = m_cyc / C;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_frame[k-1];
  endfunction

  function automatic void modelStep(input bit r, input bit v, input logic [7:0] d);
    bit nonempty;
    m_accept = 1'b0;
    if (r) begin
      mq.delete();
      m_active = 1'b0;
      m_cyc    = 0;
      return;
    end
    nonempty = (mq.size() > 0);
    m_accept = v && (mq.size() < DEPTH);
    if (!m_active) begin
      if (nonempty) begin
        m_frame  = mq.pop_front();
        m_active = 1'b1;
        m_cyc    = 0;
      end
    end else if (m_cyc == 10*C - 1) begin
      exp_q.push_back(m_frame);
      if (nonempty) begin
        m_frame = mq.pop_front();
        m_cyc   = 0;
      end else begin
        m_active = 1'b0;
      end
    end else begin
      m_cyc++;
    end
    if (m_accept) mq.push_back(d);
  endfunction

  task automatic decoderStep(input bit r);
    if (r) begin
      dec_active = 1'b0;
    end else if (!dec_active) begin
      if (line == 1'b0) begin
        dec_active = 1'b1;
        dec_cnt    = 0;
      end
    end else begin
      dec_cnt++;
      if (line != prev_line) checkOutput("bit_edge_align", dec_cnt % C, 0);
      if (dec_cnt % C == C/2) dec_bits[dec_cnt / C] = line;
      if (dec_cnt == 9*C + C/2) begin
        checkOutput("dec_start_bit", int'(dec_bits[0]), 0);
        checkOutput("dec_stop_bit", int'(dec_bits[9]), 1);
        dec_q.push_back(dec_bits[8:1]);
        dec_active = 1'b0;
      end
    end
    prev_line = line;
  endtask

  task automatic applyStimulus(input bit r, input bit v, input logic [7:0] d);
    rst      = r;
    tx_valid = v;
    tx_data  = d;
    @(posedge clk);
    modelStep(r, v, d);
    #1;
    checkOutput("line", int'(line), int'(modelLine()));
    checkOutput("tx_ready", int'(tx_ready), int'(mq.size() < DEPTH));
    checkOutput("busy", int'(busy), int'(m_active || mq.size() > 0));
    checkOutput("fifo_level", int'(fifo_level), mq.size());
    decoderStep(r);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (busy && n < 2000) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      n++;
    end
    if (busy) checkOutput({name, "_drain_timeout"}, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic compareQueues(input string name);
    int n;
    checkOutput({name, "_byte_count"}, dec_q.size(), exp_q.size());
    n = (dec_q.size() < exp_q.size()) ? dec_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) checkOutput({name, "_byte"}, int'(dec_q[i]), int'(exp_q[i]));
    dec_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] b4[6];
    int idx, waited, peak, cnt, sent, guard;

    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    m_active = 1'b0; m_cyc = 0; dec_active = 1'b0; dec_cnt = 0; prev_line = 1'b1;

    vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0};
    vecs[1] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0};
    vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0};
    vecs[3] = '{1'b0, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b0, 0};
    vecs[4] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 0};
    a5_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    $display("[TB] reset and single byte 0xA5");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].data);
      checkOutput("vec_line", int'(line), int'(vecs[i].line));
      checkOutput("vec_ready", int'(tx_ready), int'(vecs[i].ready));
      checkOutput("vec_busy", int'(busy), int'(vecs[i].busy));
      checkOutput("vec_level", int'(fifo_level), vecs[i].level);
    end
    for (int cyc = 1; cyc < 40; cyc++) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput("a5_line", int'(line), int'(a5_bits[cyc / C]));
      if (cyc == 39) checkOutput("a5_busy_last", int'(busy), 1);
    end
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("a5_busy_end", int'(busy), 0);
    drain("a5");
    compareQueues("a5");

    $display("[TB] back-to-back 0x00 0xFF 0x55");
    peak = 0;
    applyStimulus(1'b0, 1'b1, 8'h00);
    if (int'(fifo_level) > peak) peak = int'(fifo_level);
    applyStimulus(1'b0, 1'b1, 8'hFF);
    if (int'(fifo_level) > peak) peak = int'(fifo_level);
    applyStimulus(1'b0, 1'b1, 8'h55);
    if (int'(fifo_level) > peak) peak = int'(fifo_level);
    cnt = 0;
    while (busy && cnt < 500) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
      cnt++;
    end
    checkOutput("b2b_level_peak", peak, 2);
    checkOutput("b2b_busy_cycles", cnt, 119);
    drain("b2b");
    checkOutput("b2b_frames", exp_q.size(), 3);
    compareQueues("b2b");

    $display("[TB] full FIFO with 6 bytes held valid");
    b4 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    idx = 0; waited = 0; guard = 0;
    while (idx < 6 && guard < 300) begin
      applyStimulus(1'b0, 1'b1, b4[idx]);
      guard++;
      if (idx == 5) waited++;
      if (m_accept) begin
        idx++;
        if (idx == 5) begin
          checkOutput("full_ready", int'(tx_ready), 0);
          checkOutput("full_level", int'(fifo_level), 4);
        end
      end
    end
    checkOutput("full_all_accepted", idx, 6);
    checkOutput("full_sixth_wait", waited, 38);
    drain("full");
    compareQueues("full");

    $display("[TB] reset mid-frame");
    applyStimulus(1'b0, 1'b1, 8'h3C);
    applyStimulus(1'b0, 1'b1, 8'hAA);
    applyStimulus(1'b0, 1'b1, 8'hBB);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("mid_level_before", int'(fifo_level), 2);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("mid_line", int'(line), 1);
    checkOutput("mid_level", int'(fifo_level), 0);
    checkOutput("mid_busy", int'(busy), 0);
    exp_q.delete();
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h81);
    drain("mid");
    checkOutput("mid_frames", exp_q.size(), 1);
    compareQueues("mid");

    $display("[TB] random scoreboard");
    sent = 0; guard = 0;
    while (sent < 200 && guard < 20000) begin
      applyStimulus(1'b0, ($urandom_range(0, 3) != 0), 8'($urandom));
      if (m_accept) sent++;
      guard++;
    end
    checkOutput("rand_sent", sent, 200);
    drain("rand");
    checkOutput("rand_frames", exp_q.size(), 200);
    compareQueues("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
